// File: rtl/qnigma_sum_feed.sv
// Serial-to-parallel frame gatherer feeding the qnigma_sum adder tree, with latency-matched valid.
// Optional rounded-average output is built when QNIGMA_SUM_FEED_AVG_EN is defined.
module qnigma_sum_feed #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_val,
  input  logic [W-1:0]            in_dat,
  output logic                    in_rdy,
  input  logic                    sync,
  output logic [(2**N)*W-1:0]     out_vec,
  output logic                    out_stb,
  output logic                    res_val,
  output logic [15:0]             frm_cnt,
  output logic [7:0]              drop_cnt
`ifdef QNIGMA_SUM_FEED_AVG_EN
  ,
  input  logic [W+N-1:0]          sum_res,
  output logic [W-1:0]            avg_dat,
  output logic                    avg_val
`endif
);

  localparam int unsigned Depth   = 2 ** N;
  localparam logic [N-1:0] CntLast = '1;

  logic                   rdy_q;
  logic [N-1:0]           cnt_q, cnt_d;
  logic [Depth*W-1:0]     buf_q, buf_d;
  logic [Depth*W-1:0]     vec_q, vec_d;
  logic                   stb_q;
  logic [N-1:0]           dly_q, dly_d;
  logic [15:0]            frm_q, frm_d;
  logic [7:0]             drop_q, drop_d;
  logic                   accept, done;
  logic [N-1:0]           widx;

  always_comb begin
    accept = in_val & rdy_q;
    done   = accept & (cnt_q == CntLast);
    // A sync only redirects the write when it is not completing the current frame.
    widx   = (sync & ~done) ? '0 : cnt_q;

    buf_d = buf_q;
    if (accept) buf_d[widx*W +: W] = in_dat;

    cnt_d = cnt_q;
    if (done)        cnt_d = '0;
    else if (sync)   cnt_d = accept ? N'(1) : '0;
    else if (accept) cnt_d = cnt_q + N'(1);

    vec_d  = done ? buf_d : vec_q;
    frm_d  = done ? frm_q + 16'd1 : frm_q;
    drop_d = (sync & (cnt_q != '0) & ~done & (drop_q != 8'hff)) ? drop_q + 8'd1 : drop_q;
    dly_d  = N'({dly_q, stb_q});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
      buf_q  <= '0;
      vec_q  <= '0;
      stb_q  <= 1'b0;
      dly_q  <= '0;
      frm_q  <= '0;
      drop_q <= '0;
    end else begin
      rdy_q  <= 1'b1;
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      vec_q  <= vec_d;
      stb_q  <= done;
      dly_q  <= dly_d;
      frm_q  <= frm_d;
      drop_q <= drop_d;
    end
  end

  assign in_rdy   = rdy_q;
  assign out_vec  = vec_q;
  assign out_stb  = stb_q;
  assign res_val  = dly_q[N-1];
  assign frm_cnt  = frm_q;
  assign drop_cnt = drop_q;

`ifdef QNIGMA_SUM_FEED_AVG_EN
  logic [W+N:0] avg_sum, avg_shr;
  logic [W-1:0] avg_d;
  logic [W-1:0] avg_q;
  logic         avg_val_q;

  always_comb begin
    avg_sum = {1'b0, sum_res} + ((W+N+1)'(1) << (N-1));
    avg_shr = avg_sum >> N;
    avg_d   = (|avg_shr[W+N:W]) ? '1 : avg_shr[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_q     <= '0;
      avg_val_q <= 1'b0;
    end else begin
      avg_val_q <= res_val;
      if (res_val) avg_q <= avg_d;
    end
  end

  assign avg_dat = avg_q;
  assign avg_val = avg_val_q;
`endif

endmodule

// File: tb/tb_qnigma_sum_feed.sv
// Directed bench for qnigma_sum_feed at W=8, N=2; average checks build with QNIGMA_SUM_FEED_AVG_EN.
module tb_qnigma_sum_feed;

  localparam int unsigned W = 8;
  localparam int unsigned N = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_val;
  logic [W-1:0]    in_dat;
  logic            in_rdy;
  logic            sync;
  logic [4*W-1:0]  out_vec;
  logic            out_stb;
  logic            res_val;
  logic [15:0]     frm_cnt;
  logic [7:0]      drop_cnt;
`ifdef QNIGMA_SUM_FEED_AVG_EN
  logic [W+N-1:0]  sum_res;
  logic [W-1:0]    avg_dat;
  logic            avg_val;
`endif

  int n_cmp = 0;
  int n_err = 0;

  qnigma_sum_feed #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_dat   (in_dat),
    .in_rdy   (in_rdy),
    .sync     (sync),
    .out_vec  (out_vec),
    .out_stb  (out_stb),
    .res_val  (res_val),
    .frm_cnt  (frm_cnt),
    .drop_cnt (drop_cnt)
`ifdef QNIGMA_SUM_FEED_AVG_EN
    ,
    .sum_res  (sum_res),
    .avg_dat  (avg_dat),
    .avg_val  (avg_val)
`endif
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after the rising edge, then inputs for the next edge are set.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] v);
    in_val = 1'b1;
    in_dat = v;
    tick();
    in_val = 1'b0;
  endtask

  task automatic idle();
    in_val = 1'b0;
    sync   = 1'b0;
    tick();
  endtask

  function automatic int unsigned vsum(input logic [4*W-1:0] v);
    int unsigned s = 0;
    for (int k = 0; k < 4; k++) s += int'(v[k*W +: W]);
    return s;
  endfunction

  initial begin
    rst_n  = 1'b0;
    in_val = 1'b0;
    in_dat = '0;
    sync   = 1'b0;
`ifdef QNIGMA_SUM_FEED_AVG_EN
    sum_res = 10'd10;
`endif
    tick();
    tick();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_stb", out_stb, 0);
    chk("rst_res_val", res_val, 0);
    chk("rst_frm_cnt", frm_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_rdy", in_rdy, 1);

    // Frame 1,2,3,4 back to back
    send(8'd1); chk("f1_stb0", out_stb, 0);
    send(8'd2); chk("f1_stb1", out_stb, 0);
    send(8'd3); chk("f1_stb2", out_stb, 0);
    send(8'd4);
    chk("f1_stb", out_stb, 1);
    chk("f1_vec", out_vec, {8'd4, 8'd3, 8'd2, 8'd1});
    chk("f1_frm", frm_cnt, 1);
    idle();
    chk("f1_stb_end", out_stb, 0);
    chk("f1_res_early", res_val, 0);
    idle();
    chk("f1_res", res_val, 1);
    chk("f1_sum", vsum(out_vec), 10);
    idle();
    chk("f1_res_end", res_val, 0);
`ifdef QNIGMA_SUM_FEED_AVG_EN
    chk("avg10_val", avg_val, 1);
    chk("avg10_dat", avg_dat, 3);
    sum_res = 10'd1021;
`endif

    // Same samples with gaps
    send(8'd1); idle();
    send(8'd2); idle(); idle();
    send(8'd3);
    chk("f2_stb_early", out_stb, 0);
    send(8'd4);
    chk("f2_stb", out_stb, 1);
    chk("f2_vec", out_vec, {8'd4, 8'd3, 8'd2, 8'd1});
    chk("f2_frm", frm_cnt, 2);
    chk("f2_drop", drop_cnt, 0);
    idle();
    idle();
    chk("f2_res", res_val, 1);
    idle();
`ifdef QNIGMA_SUM_FEED_AVG_EN
    chk("avg_sat_val", avg_val, 1);
    chk("avg_sat_dat", avg_dat, 255);
`endif

    // Partial frame discarded by sync carrying a new first sample
    send(8'd9);
    send(8'd9);
    sync = 1'b1;
    send(8'd5);
    sync = 1'b0;
    chk("f3_drop", drop_cnt, 1);
    chk("f3_stb_sync", out_stb, 0);
    send(8'd6);
    send(8'd7);
    send(8'd8);
    chk("f3_stb", out_stb, 1);
    chk("f3_vec", out_vec, {8'd8, 8'd7, 8'd6, 8'd5});
    chk("f3_frm", frm_cnt, 3);
    idle();
    idle();

    // Sync on the final sample completes the frame without a drop
    send(8'd1);
    send(8'd2);
    send(8'd3);
    sync = 1'b1;
    send(8'd4);
    sync = 1'b0;
    chk("f4_stb", out_stb, 1);
    chk("f4_vec", out_vec, {8'd4, 8'd3, 8'd2, 8'd1});
    chk("f4_drop", drop_cnt, 1);
    chk("f4_frm", frm_cnt, 4);
    idle();
    idle();
    chk("f4_res", res_val, 1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_empty_drop", drop_cnt, 1);
    send(8'd9);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_alone_drop", drop_cnt, 2);
    chk("sync_alone_vec", out_vec, {8'd4, 8'd3, 8'd2, 8'd1});

    // Twelve consecutive samples: strobes every 4 cycles, res_val 2 cycles later
    for (int i = 0; i < 16; i++) begin
      in_val = (i < 12);
      in_dat = W'(i);
      tick();
      chk($sformatf("bb_stb%0d", i), out_stb, ((i % 4) == 3) && (i < 12));
      chk($sformatf("bb_res%0d", i), res_val, (i == 5) || (i == 9) || (i == 13));
    end
    in_val = 1'b0;
    chk("bb_frm", frm_cnt, 7);
    chk("bb_vec", out_vec, {8'd11, 8'd10, 8'd9, 8'd8});

    // Drop counter saturates
    for (int i = 0; i < 260; i++) begin
      send(8'd1);
      sync = 1'b1;
      tick();
      sync = 1'b0;
    end
    chk("drop_sat", drop_cnt, 255);

    // Reset with a partial frame and a res_val pending
    send(8'd10); send(8'd11); send(8'd12); send(8'd13);
    chk("rs_stb", out_stb, 1);
    send(8'd14);
    rst_n = 1'b0;
    tick();
    chk("rs_res_cancel", res_val, 0);
    chk("rs_in_rdy", in_rdy, 0);
    chk("rs_vec", out_vec, 0);
    chk("rs_frm", frm_cnt, 0);
    chk("rs_drop", drop_cnt, 0);
    tick();
    chk("rs_res_cancel2", res_val, 0);
    rst_n = 1'b1;
    tick();
    chk("rs_in_rdy_rel", in_rdy, 1);
    chk("rs_res_after", res_val, 0);
    send(8'd1); send(8'd2); send(8'd3);
    chk("rs_cnt_zero", out_stb, 0);
    send(8'd4);
    chk("rs_f_stb", out_stb, 1);
    chk("rs_f_vec", out_vec, {8'd4, 8'd3, 8'd2, 8'd1});
    chk("rs_f_frm", frm_cnt, 1);
    chk("rs_f_drop", drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qnigma_sum_feed.md
Name: qnigma_sum_feed

Overview:
Upstream stage for the pipelined power-of-two adder tree `qnigma_sum`.
- Gathers a serial stream of W-bit samples into a packed 2**N-element vector, one frame at a time.
- Presents each completed frame as a stable parallel word to the tree.
- Generates a valid strobe delayed to match the tree's N-cycle latency, so downstream logic knows when the tree's `res` is meaningful.
- Provides frame resync and frame/drop accounting for the averaging path.

Parameters:
- W, 8, sample width in bits (must equal the tree's W)
- N, 4, log2 of samples per frame; also the tree latency in cycles (N >= 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_val  in  1  input sample valid
- in_dat  in  W  input sample
- in_rdy  out  1  block can accept a sample
- sync  in  1  frame restart; discards any partial frame
- out_vec  out  2**N x W  packed frame to the tree; element k = k-th sample of the frame
- out_stb  out  1  one-cycle pulse: out_vec updated this cycle
- res_val  out  1  one-cycle pulse: tree res valid this cycle
- frm_cnt  out  16  completed frames, wraps
- drop_cnt  out  8  discarded partial frames, saturating
- sum_res  in  W+N  tree result (present only with QNIGMA_SUM_FEED_AVG_EN)
- avg_dat  out  W  rounded average (present only with QNIGMA_SUM_FEED_AVG_EN)
- avg_val  out  1  avg_dat valid pulse (present only with QNIGMA_SUM_FEED_AVG_EN)

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous, active-low, sampled on the clk rising edge.
- Reset values: out_vec=0, out_stb=0, res_val=0, frm_cnt=0, drop_cnt=0, in_rdy=0, fill index cnt=0, fill buffer=0, delay line cleared; avg_dat=0 and avg_val=0 when AVG_EN.
- in_rdy: registered; 0 during reset, 1 from the first cycle after rst_n samples high, then stays 1. The tree has no backpressure, so the block never stalls.
- Accept: a sample is accepted when in_val && in_rdy. It is written to fill buffer element cnt, then cnt increments. Gaps in in_val are allowed; cnt holds.
- Frame completion: when cnt==2**N-1 is accepted at edge t:
  - the complete buffer, including that sample, is copied to out_vec at edge t;
  - out_stb=1 for the following cycle c;
  - cnt wraps to 0;
  - frm_cnt increments (wraps at 2**16).
- out_vec: holds its value between completions. Back-to-back frames give out_stb every 2**N accepted samples with no dead cycle.
- res_val: out_stb delayed by an N-flop shift register, so res_val is high in cycle c+N, aligned with the tree's res for that frame. Multiple frames may be in flight.
- sync:
  - sets cnt=0 on that edge;
  - if cnt!=0 and no completion occurs on that edge, drop_cnt increments (saturates at 255);
  - if in_val is also high, that sample is accepted as element 0 of the new frame (cnt becomes 1);
  - a sync coinciding with acceptance of the final sample lets the completion proceed normally; no drop is counted;
  - sync never affects out_vec or in-flight res_val.
- Reset mid-operation: partial frame discarded without counting; pending res_val pulses are cancelled.

Optional Feature:
QNIGMA_SUM_FEED_AVG_EN
- Defined:
  - sum_res, avg_dat and avg_val ports exist.
  - On cycles with res_val=1, avg_dat <= (sum_res + 2**(N-1)) >> N. Rounding is half-up, computed W+N+1 bits wide, then saturated to 2**W-1.
  - avg_val pulses one cycle after res_val; avg_dat holds otherwise.
- Not defined: these ports and their logic are absent; the block only feeds and tracks the tree.

Test Plan:
- W=8,N=2: reset release, then in_dat 1,2,3,4 on consecutive cycles -> out_vec={4,3,2,1}, single out_stb pulse, res_val 2 cycles later, tree res=10, frm_cnt=1.
- Same samples with in_val gapped (1,-,2,-,-,3,4) -> identical out_vec; out_stb only after the 4th accept; drop_cnt=0.
- 2 samples (9,9), then sync with in_val and in_dat=5, then 6,7,8 -> drop_cnt=1, out_vec={8,7,6,5}.
- 12 consecutive samples 0..11 -> three out_stb pulses, exactly 4 cycles apart; three res_val pulses each 2 cycles after their out_stb; frm_cnt=3.
- Reset asserted after 3 samples and with one res_val pending -> no res_val appears, cnt=0, in_rdy=0 during reset and 1 one cycle after release.
- AVG_EN, N=2: sum_res=10 at res_val -> avg_dat=3 and avg_val one cycle later; sum_res=1021 (W=8) -> avg_dat=255.
